// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch stage: FSM states, select encodings and widths.
package fetch_pkg;

    localparam int XLEN  = 32;
    localparam int CNT_W = 3;

    localparam logic [0:XLEN-1] DEFAULT_NOP = 32'h0000_0000;

    typedef enum logic {
        RUN     = 1'b0,
        BR_WAIT = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        PC_HOLD     = 2'd0,
        PC_INC      = 2'd1,
        PC_REDIRECT = 2'd2
    } pc_sel_e;

    typedef enum logic [1:0] {
        IFID_HOLD  = 2'd0,
        IFID_FETCH = 2'd1,
        IFID_NOP   = 2'd2
    } ifid_sel_e;

endpackage

// File: rtl/fetch_ctrl.sv
// Fetch arbitration FSM: decides each cycle how the PC and the IF/ID register update.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int BRANCH_BUBBLES = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load_bubble,
    input  logic       branch_bubble,
    input  logic       redirect_valid,
    output logic [1:0] pc_load_sel,
    output logic [1:0] ifid_sel
);

    localparam logic [CNT_W-1:0] BUBBLE_INIT = CNT_W'(BRANCH_BUBBLES);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    pc_sel_e           pc_sel;
    ifid_sel_e         ifid_sel_int;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pc_sel       = PC_HOLD;
        ifid_sel_int = IFID_HOLD;

        if (redirect_valid) begin
            pc_sel       = PC_REDIRECT;
            ifid_sel_int = IFID_NOP;
            state_d      = RUN;
            cnt_d        = '0;
        end else if (!load_bubble) begin
            case (state_q)
                RUN: begin
                    pc_sel       = PC_INC;
                    ifid_sel_int = IFID_FETCH;
                    if (branch_bubble) begin
                        cnt_d   = BUBBLE_INIT;
                        state_d = BR_WAIT;
                    end
                end
                BR_WAIT: begin
                    // branch_bubble is deliberately ignored while draining bubbles
                    ifid_sel_int = IFID_NOP;
                    cnt_d        = cnt_q - 1'b1;
                    if (cnt_q <= CNT_W'(1)) begin
                        state_d = RUN;
                    end
                end
                default: begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign pc_load_sel = pc_sel;
    assign ifid_sel    = ifid_sel_int;

endmodule

// File: rtl/fetch_stage.sv
// PC register and IF/ID pipeline register; optional perf counters built when FETCH_PERF_EN is defined.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [0:XLEN-1] RESET_PC       = 32'h0000_0000,
    parameter logic [0:XLEN-1] NOP_WORD       = DEFAULT_NOP,
    parameter int              BRANCH_BUBBLES = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic [0:31]   imem_addr,
    input  logic [0:31]   imem_data,
    input  logic          load_bubble,
    input  logic          branch_bubble,
    input  logic          redirect_valid,
    input  logic [0:31]   redirect_target,
    output logic [0:31]   decode_inst,
    output logic [0:31]   decode_pc_plus_4,
    output logic          decode_valid
`ifdef FETCH_PERF_EN
    ,
    output logic [0:31]   perf_stall_cnt,
    output logic [0:31]   perf_bubble_cnt
`endif
);

    logic [1:0]       pc_load_sel;
    logic [1:0]       ifid_sel;
    logic [0:XLEN-1]  pc_q, pc_d, pc_plus_4;
    logic [0:XLEN-1]  inst_q, inst_d;
    logic [0:XLEN-1]  pc4_q, pc4_d;
    logic             valid_q, valid_d;

    fetch_ctrl #(
        .BRANCH_BUBBLES (BRANCH_BUBBLES)
    ) u_ctrl (
        .clk            (clk),
        .rst_n          (rst_n),
        .load_bubble    (load_bubble),
        .branch_bubble  (branch_bubble),
        .redirect_valid (redirect_valid),
        .pc_load_sel    (pc_load_sel),
        .ifid_sel       (ifid_sel)
    );

    assign pc_plus_4 = pc_q + XLEN'(4);

    always_comb begin
        pc_d = pc_q;
        case (pc_sel_e'(pc_load_sel))
            PC_INC:      pc_d = pc_plus_4;
            PC_REDIRECT: pc_d = redirect_target;
            default:     pc_d = pc_q;
        endcase
    end

    // A bubble carries the PC it stands in for: the redirect target on squash, the held PC in BR_WAIT.
    always_comb begin
        inst_d  = inst_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        case (ifid_sel_e'(ifid_sel))
            IFID_FETCH: begin
                inst_d  = imem_data;
                pc4_d   = pc_plus_4;
                valid_d = 1'b1;
            end
            IFID_NOP: begin
                inst_d  = NOP_WORD;
                pc4_d   = pc_d;
                valid_d = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= RESET_PC;
            inst_q  <= NOP_WORD;
            pc4_q   <= RESET_PC;
            valid_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
        end
    end

    assign imem_addr        = pc_q;
    assign decode_inst      = inst_q;
    assign decode_pc_plus_4 = pc4_q;
    assign decode_valid     = valid_q;

`ifdef FETCH_PERF_EN
    logic [0:31] stall_cnt_q, stall_cnt_d;
    logic [0:31] bubble_cnt_q, bubble_cnt_d;
    logic        stall_inc, bubble_inc;

    assign stall_inc  = load_bubble && !redirect_valid;
    assign bubble_inc = (ifid_sel == IFID_NOP);

    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (stall_inc && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
        if (bubble_inc && (bubble_cnt_q != '1)) begin
            bubble_cnt_d = bubble_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign perf_stall_cnt  = stall_cnt_q;
    assign perf_bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed, table-driven bench for fetch_stage with BRANCH_BUBBLES = 2 (perf checks when FETCH_PERF_EN).
module tb_fetch_stage;

    typedef struct {
        logic        load;
        logic        branch;
        logic        redir;
        logic [0:31] target;
        logic [0:31] expAddr;
        logic [0:31] expInst;
        logic [0:31] expPc4;
        logic        expValid;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [0:31] imem_addr;
    logic [0:31] imem_data;
    logic        load_bubble;
    logic        branch_bubble;
    logic        redirect_valid;
    logic [0:31] redirect_target;
    logic [0:31] decode_inst;
    logic [0:31] decode_pc_plus_4;
    logic        decode_valid;
`ifdef FETCH_PERF_EN
    logic [0:31] perf_stall_cnt;
    logic [0:31] perf_bubble_cnt;
`endif

    int checks = 0;
    int errors = 0;
    int expStall = 0;
    int expBubble = 0;
    vec_t vecs[28];

    always #5 clk = ~clk;

    // Instruction memory model: word at address A is 0x1000_0000 + A/4 + 1.
    assign imem_data = 32'h1000_0000 + (imem_addr >> 2) + 32'd1;

    fetch_stage #(
        .RESET_PC       (32'h0000_0000),
        .NOP_WORD       (32'h0000_0000),
        .BRANCH_BUBBLES (2)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .imem_addr        (imem_addr),
        .imem_data        (imem_data),
        .load_bubble      (load_bubble),
        .branch_bubble    (branch_bubble),
        .redirect_valid   (redirect_valid),
        .redirect_target  (redirect_target),
        .decode_inst      (decode_inst),
        .decode_pc_plus_4 (decode_pc_plus_4),
        .decode_valid     (decode_valid)
`ifdef FETCH_PERF_EN
        ,
        .perf_stall_cnt   (perf_stall_cnt),
        .perf_bubble_cnt  (perf_bubble_cnt)
`endif
    );

    task automatic checkField(input string name, input string field,
                              input logic [0:31] act, input logic [0:31] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s.%s actual=%h required=%h", name, field, act, exp);
        end
    endtask

    task automatic checkOutput(input string name, input vec_t v);
        checkField(name, "imem_addr", imem_addr, v.expAddr);
        checkField(name, "decode_inst", decode_inst, v.expInst);
        checkField(name, "decode_pc_plus_4", decode_pc_plus_4, v.expPc4);
        checkField(name, "decode_valid", {31'b0, decode_valid}, {31'b0, v.expValid});
`ifdef FETCH_PERF_EN
        checkField(name, "perf_stall_cnt", perf_stall_cnt, expStall);
        checkField(name, "perf_bubble_cnt", perf_bubble_cnt, expBubble);
`endif
    endtask

    task automatic applyStimulus(input vec_t v);
        load_bubble     = v.load;
        branch_bubble   = v.branch;
        redirect_valid  = v.redir;
        redirect_target = v.target;
        if (v.load && !v.redir) expStall++;
        if (v.redir || (!v.load && !v.expValid)) expBubble++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t v;
        vecs[0]  = '{0, 0, 0, 32'h0,        32'h4,        32'h1000_0001, 32'h4,        1};
        vecs[1]  = '{0, 0, 0, 32'h0,        32'h8,        32'h1000_0002, 32'h8,        1};
        vecs[2]  = '{0, 0, 0, 32'h0,        32'hC,        32'h1000_0003, 32'hC,        1};
        vecs[3]  = '{0, 0, 0, 32'h0,        32'h10,       32'h1000_0004, 32'h10,       1};
        vecs[4]  = '{0, 0, 1, 32'h4,        32'h4,        32'h0,         32'h4,        0};
        vecs[5]  = '{0, 0, 0, 32'h0,        32'h8,        32'h1000_0002, 32'h8,        1};
        vecs[6]  = '{1, 0, 0, 32'h0,        32'h8,        32'h1000_0002, 32'h8,        1};
        vecs[7]  = '{1, 0, 0, 32'h0,        32'h8,        32'h1000_0002, 32'h8,        1};
        vecs[8]  = '{1, 0, 0, 32'h0,        32'h8,        32'h1000_0002, 32'h8,        1};
        vecs[9]  = '{0, 0, 0, 32'h0,        32'hC,        32'h1000_0003, 32'hC,        1};
        vecs[10] = '{0, 1, 0, 32'h0,        32'h10,       32'h1000_0004, 32'h10,       1};
        vecs[11] = '{0, 1, 0, 32'h0,        32'h10,       32'h0,         32'h10,       0};
        vecs[12] = '{0, 1, 0, 32'h0,        32'h10,       32'h0,         32'h10,       0};
        vecs[13] = '{0, 0, 0, 32'h0,        32'h14,       32'h1000_0005, 32'h14,       1};
        vecs[14] = '{0, 0, 1, 32'hC,        32'hC,        32'h0,         32'hC,        0};
        vecs[15] = '{0, 1, 0, 32'h0,        32'h10,       32'h1000_0004, 32'h10,       1};
        vecs[16] = '{0, 0, 1, 32'h40,       32'h40,       32'h0,         32'h40,       0};
        vecs[17] = '{0, 0, 0, 32'h0,        32'h44,       32'h1000_0011, 32'h44,       1};
        vecs[18] = '{1, 0, 1, 32'h80,       32'h80,       32'h0,         32'h80,       0};
        vecs[19] = '{0, 0, 0, 32'h0,        32'h84,       32'h1000_0021, 32'h84,       1};
        vecs[20] = '{0, 1, 0, 32'h0,        32'h88,       32'h1000_0022, 32'h88,       1};
        vecs[21] = '{1, 0, 0, 32'h0,        32'h88,       32'h1000_0022, 32'h88,       1};
        vecs[22] = '{0, 0, 0, 32'h0,        32'h88,       32'h0,         32'h88,       0};
        vecs[23] = '{0, 0, 0, 32'h0,        32'h88,       32'h0,         32'h88,       0};
        vecs[24] = '{0, 0, 0, 32'h0,        32'h8C,       32'h1000_0023, 32'h8C,       1};
        vecs[25] = '{0, 0, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0,       32'hFFFF_FFFC, 0};
        vecs[26] = '{0, 0, 0, 32'h0,        32'h0,        32'h5000_0000, 32'h0,        1};
        vecs[27] = '{0, 0, 0, 32'h0,        32'h4,        32'h1000_0001, 32'h4,        1};

        rst_n           = 1'b0;
        load_bubble     = 1'b0;
        branch_bubble   = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = 32'h0;
        #12;
        v = '{0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 0};
        checkOutput("reset", v);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // IDLE cycle above already fetched address 0; restart from a clean reset edge.
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < 28; i++) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("vec%0d", i), vecs[i]);
        end

        // Branch at PC=4, one bubble cycle, then async reset mid-BR_WAIT.
        v = '{0, 1, 0, 32'h0, 32'h8, 32'h1000_0002, 32'h8, 1};
        applyStimulus(v);
        checkOutput("rstBranch", v);
        v = '{0, 0, 0, 32'h0, 32'h8, 32'h0, 32'h8, 0};
        applyStimulus(v);
        checkOutput("rstBubble", v);
        #2;
        rst_n = 1'b0;
        #1;
        expStall  = 0;
        expBubble = 0;
        v = '{0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 0};
        checkOutput("asyncReset", v);
        #1;
        rst_n = 1'b1;
        v = '{0, 0, 0, 32'h0, 32'h4, 32'h1000_0001, 32'h4, 1};
        applyStimulus(v);
        checkOutput("afterReset", v);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

PC generation and IF/ID pipeline register for the five-stage pipeline. Each cycle the block fetches the instruction word at the current PC from a single-cycle instruction memory and latches it, with its PC+4, into the register read by decode. It consumes `load_bubble` and `branch_bubble` from the fetch hazard unit and the branch redirect from decode. It implements stall, bubble-insertion and squash behaviour, arbitrated by a small state machine.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset
- `NOP_WORD`, 32'h0000_0000, instruction encoding that decode treats as a no-op
- `BRANCH_BUBBLES`, 1, NOP cycles inserted after a fetched branch (legal range 1–7)
- `clk` in 1: single clock, rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `imem_addr` out [0:31]: current PC; combinationally equal to the PC register
- `imem_data` in [0:31]: instruction at `imem_addr`, valid in the same cycle
- `load_bubble` in 1: load-use hazard; freeze fetch
- `branch_bubble` in 1: branch present in fetch; start bubble sequence
- `redirect_valid` in 1: decode has resolved a taken branch or jump
- `redirect_target` in [0:31]: new PC when `redirect_valid`
- `decode_inst` out [0:31]: IF/ID instruction
- `decode_pc_plus_4` out [0:31]: IF/ID PC+4
- `decode_valid` out 1: IF/ID holds a real instruction, not a bubble
- `perf_stall_cnt` out [0:31]: load-stall cycles; present only with `FETCH_PERF_EN`
- `perf_bubble_cnt` out [0:31]: branch-bubble and squash cycles; present only with `FETCH_PERF_EN`

## Operation
- Reset (async assert, sync release) sets the following values:
  - PC = `RESET_PC`
  - `decode_inst` = `NOP_WORD`
  - `decode_pc_plus_4` = `RESET_PC`
  - `decode_valid` = 0
  - state = RUN
  - bubble counter = 0
  - perf counters = 0
- PC+4 is computed with modulo 2^32 arithmetic; 32'hFFFF_FFFC wraps to 0. PC bits [30:31] are always loaded as supplied; no alignment check.
- Priority per cycle: `redirect_valid` > `load_bubble` > `branch_bubble` > normal fetch.
- Redirect (any state):
  - PC ← `redirect_target`
  - IF/ID ← {`NOP_WORD`, `redirect_target`, valid=0}
  - state ← RUN, counter ← 0
- State RUN:
  - `load_bubble`: PC and IF/ID hold their values; state unchanged.
  - `branch_bubble`:
    - IF/ID ← {`imem_data`, PC+4, 1}
    - PC ← PC+4
    - counter ← `BRANCH_BUBBLES`
    - state ← BR_WAIT
  - Otherwise: IF/ID ← {`imem_data`, PC+4, 1}; PC ← PC+4.
- State BR_WAIT:
  - `load_bubble`: PC, IF/ID and counter hold.
  - Otherwise:
    - PC holds.
    - IF/ID ← {`NOP_WORD`, PC, 0}.
    - Counter decrements.
    - When the counter reaches 0, state ← RUN.
  - `branch_bubble` is ignored in BR_WAIT.
- Counter width is 3 bits.

## Timing
- Fetch-to-decode latency is 1 cycle: the word present at `imem_data` in cycle N appears on `decode_inst` in cycle N+1.
- Redirect in cycle N:
  - `imem_addr` = target in N+1.
  - Target instruction is in IF/ID in N+2.
  - Exactly one squash bubble is visible in IF/ID in N+1.
- A branch fetched in cycle N is followed by exactly `BRANCH_BUBBLES` cycles with `decode_valid`=0, unless a redirect or `load_bubble` intervenes.
- `load_bubble` held for K cycles freezes IF/ID for exactly K cycles; no instruction is lost or duplicated.
- `rst_n` asserted mid-BR_WAIT aborts the sequence immediately. No pending redirect survives reset.

## Configuration
- `FETCH_PERF_EN` defined:
  - `perf_stall_cnt` increments on each cycle with `load_bubble` and no redirect.
  - `perf_bubble_cnt` increments on each cycle in which IF/ID loads a bubble, whether squash or BR_WAIT.
  - Both counters saturate at 32'hFFFF_FFFF.
- `FETCH_PERF_EN` undefined: the counters, their logic and both perf ports are absent. Functional behaviour is identical in both builds.

## Structure
- Shared package `fetch_pkg` holds:
  - the state encoding (RUN, BR_WAIT)
  - the instruction and address width constant (32)
  - the counter width constant (3)
  - the default NOP constant
- Sub-module `fetch_ctrl` contains the state machine and bubble counter. It outputs `pc_load_sel` (hold / inc / redirect) and `ifid_sel` (hold / fetch / nop).
- The top level holds the PC register, the IF/ID registers and the optional perf counters.

## Test plan
- Reset, then 4 free-running cycles with `imem_data` = 0x1000_0001..4: `decode_inst` sequence 1..4; `decode_pc_plus_4` 4, 8, 12, 16; `imem_addr` 0x10 after the 4th cycle.
- `load_bubble` for 3 cycles at PC=0x8: `imem_addr` stays 0x8; IF/ID holds word at 0x4 for 3 cycles; next word is the one at 0x8.
- `branch_bubble` at PC=0xC with `BRANCH_BUBBLES`=2, no redirect: branch word in IF/ID, then 2 cycles `decode_valid`=0 with `NOP_WORD`, then word at 0x10.
- `branch_bubble` at PC=0xC, redirect to 0x40 in the first BR_WAIT cycle: one squash bubble, `imem_addr`=0x40, next valid `decode_pc_plus_4`=0x44.
- `redirect_valid` and `load_bubble` together: redirect wins; PC=target next cycle; `perf_stall_cnt` unchanged.
- PC=0xFFFF_FFFC normal fetch: `decode_pc_plus_4`=0, next `imem_addr`=0. Then `rst_n` low mid-BR_WAIT: all outputs return to reset values asynchronously.
